uart_tx_arbiter: RTL

//  Shares the single usb_uart transmit byte stream (uart_in_* pipeline) between N_REQ

---
 rtl/uart_tx_arbiter_pkg.sv | 18 +
 rtl/uart_tx_arbiter_if.sv | 27 ++
 rtl/uart_tx_arbiter_rr_pick.sv | 32 +++
 rtl/uart_tx_arbiter.sv | 113 +++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared constants and types for the usb_uart transmit-side byte-stream blocks.
package uart_tx_arbiter_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 8;
  localparam logic [BYTE_W-1:0] EOP_DEFAULT = 8'h0A;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  // Index width for n requesters, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester byte streams plus the single outgoing byte stream toward usb_uart.
interface uart_tx_arbiter_if
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = 2
) ();

  logic [BYTE_W*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [BYTE_W-1:0]       out_data;
  logic                    out_valid;
  logic                    out_ready;

  // Environment side: requesters and the usb_uart sink.
  modport master (
    output req_data, req_valid, out_ready,
    input  req_ready, out_data, out_valid
  );

  // Arbiter side.
  modport slave (
    input  req_data, req_valid, out_ready,
    output req_ready, out_data, out_valid
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin picker: first asserted request after last, wrapping through last itself.
module uart_tx_arbiter_rr_pick
  import uart_tx_arbiter_pkg::*;
#(
  parameter  int unsigned N_REQ = 2,
  localparam int unsigned GW    = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [GW-1:0]    last,
  output logic             any,
  output logic [GW-1:0]    idx
);

  // Prefer the lowest index above last, otherwise wrap to the lowest index overall.
  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!any && req[i] && (GW'(i) > last)) begin
        any = 1'b1;
        idx = GW'(i);
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!any && req[i]) begin
        any = 1'b1;
        idx = GW'(i);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter sharing the usb_uart transmit stream between requesters.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter  int unsigned       N_REQ     = 2,
  parameter  int unsigned       MAX_BURST = 64,
  parameter  bit                USE_EOP   = 1'b1,
  parameter  logic [BYTE_W-1:0] EOP_BYTE  = EOP_DEFAULT,
  parameter  int unsigned       TIMEOUT   = 255,
  localparam int unsigned       GW        = idx_width(N_REQ)
) (
  input  logic               clk_48mhz,
  input  logic               reset,
  uart_tx_arbiter_if.slave   bus,
  output logic [GW-1:0]      grant_id,
  output logic               busy
);

  localparam int unsigned IDLE_W = CNT_W + 1;

  state_t            state;
  logic [GW-1:0]     last_grant;
  logic [CNT_W-1:0]  byte_cnt;
  logic [CNT_W-1:0]  idle_cnt;
  logic              pick_any;
  logic [GW-1:0]     pick_idx;
  logic [BYTE_W-1:0] sel_data;
  logic              sel_valid;
  logic              locked;
  logic              xfer;
  logic              rel_now;

  uart_tx_arbiter_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req  (bus.req_valid),
    .last (last_grant),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  // Granted lane selection.
  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_id == GW'(i)) begin
        sel_data  = bus.req_data[BYTE_W*i +: BYTE_W];
        sel_valid = bus.req_valid[i];
      end
    end
  end

  // Zero-latency pass-through while locked; silenced while reset is held.
  assign locked        = (state == ST_LOCK) && !reset;
  assign bus.out_data  = sel_data;
  assign bus.out_valid = locked && sel_valid;
  assign xfer          = bus.out_valid && bus.out_ready;

  always_comb begin
    bus.req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (locked && (grant_id == GW'(i))) bus.req_ready[i] = bus.out_ready;
    end
  end

  // Release only after a completed byte or on the last cycle of a valid-low stretch.
  always_comb begin
    rel_now = 1'b0;
    if (xfer) begin
      if (USE_EOP && (sel_data == EOP_BYTE))              rel_now = 1'b1;
      if ((byte_cnt + CNT_W'(1)) == CNT_W'(MAX_BURST))   rel_now = 1'b1;
    end else if (locked && !sel_valid &&
                 (({1'b0, idle_cnt} + IDLE_W'(1)) >= IDLE_W'(TIMEOUT))) begin
      rel_now = 1'b1;
    end
  end

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      grant_id   <= '0;
      last_grant <= GW'(N_REQ - 1);
      byte_cnt   <= '0;
      idle_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            grant_id <= pick_idx;
            state    <= ST_LOCK;
            busy     <= 1'b1;
          end
        end
        ST_LOCK: begin
          if (rel_now) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            last_grant <= grant_id;
            byte_cnt   <= '0;
            idle_cnt   <= '0;
          end else if (xfer) begin
            byte_cnt <= byte_cnt + CNT_W'(1);
            idle_cnt <= '0;
          end else if (!sel_valid && (idle_cnt != {CNT_W{1'b1}})) begin
            idle_cnt <= idle_cnt + CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
